// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | spi_pkg : state encoding and SPI mode constants for master/slave |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_e;

    // Modes are encoded as {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SCLK_EDGES = 16;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | spi_clk_gen : half-period divider, one-cycle tick every HALF clk |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spi_clk_gen #(
    parameter int HALF = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;

    // Counter restarts from zero whenever disabled so the first tick lands HALF cycles after enable.
    assign tick_o = en_i && (cnt_q == C_LAST);

    always_ff @(posedge clk) begin
        if (reset || !en_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | spi_master : single-byte SPI master, all four CPOL/CPHA modes    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int SCLK_FREQ = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    // HALF must come out at 2 or more for the chosen frequencies.
    localparam int HALF = CLK_FREQ / (2 * SCLK_FREQ);

    state_e     state_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       cs_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] dout_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic       cpol_q;
    logic       cpha_q;
    logic [4:0] edge_q;

    logic gen_en;
    logic tick;
    logic lead_edge;
    logic sample_now;
    logic shift_now;

    assign gen_en = (state_q != IDLE);

    spi_clk_gen #(
        .HALF (HALF)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (gen_en),
        .tick_o (tick)
    );

    // edge_q counts edges already made, so the upcoming edge is odd (leading) when edge_q is even.
    assign lead_edge  = ~edge_q[0];
    assign sample_now = lead_edge ^ cpha_q;
    assign shift_now  = ~sample_now & (cpha_q | (edge_q < 5'd14));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 8'h00;
            rx_q    <= 8'h00;
            tx_q    <= 8'h00;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            edge_q  <= 5'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= CPOL;
                    cs_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (start) begin
                        cpol_q  <= CPOL;
                        cpha_q  <= CPHA;
                        edge_q  <= 5'd0;
                        rx_q    <= 8'h00;
                        // CPHA=0 presents bit7 before the first edge; CPHA=1 drives it on edge 1.
                        tx_q    <= CPHA ? data_in : {data_in[6:0], 1'b0};
                        mosi_q  <= CPHA ? 1'b0 : data_in[7];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LEAD;
                    end
                end
                LEAD, XFER: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 5'd1;
                        if (sample_now) begin
                            rx_q <= {rx_q[6:0], MISO};
                        end
                        if (shift_now) begin
                            mosi_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        state_q <= (edge_q == 5'(SCLK_EDGES - 1)) ? TRAIL : XFER;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs_q    <= 1'b1;
                        sclk_q  <= cpol_q;
                        dout_q  <= rx_q;
                        done_q  <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign CS       = cs_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter SCLK_FREQ, default 1000000, SPI clock frequency in Hz; HALF = CLK_FREQ/(2*SCLK_FREQ) clk cycles per SCLK half-period (25 at defaults); HALF SHALL be >= 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge, single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a byte transfer.
REQ-006 data_in  input  8  byte to transmit on MOSI, MSB first.
REQ-007 CPOL  input  1  clock polarity for the next transfer.
REQ-008 CPHA  input  1  clock phase for the next transfer.
REQ-009 MISO  input  1  serial data from spi_slave.
REQ-010 SCLK  output  1  SPI clock to spi_slave.
REQ-011 MOSI  output  1  serial data to spi_slave.
REQ-012 CS  output  1  active-low slave select.
REQ-013 busy  output  1  high while a transfer or its CS-high gap is in progress.
REQ-014 done  output  1  one-cycle pulse when data_out is updated.
REQ-015 data_out  output  8  byte received on MISO, MSB first.

Function
REQ-016 States IDLE, LEAD, XFER, TRAIL, GAP; all outputs registered.
REQ-017 IDLE: CS=1, busy=0, SCLK tracks CPOL input with one-cycle latency; start=1 latches data_in, CPOL, CPHA into shadow registers and moves to LEAD (call this cycle 0).
REQ-018 start while busy=1 is ignored; CPOL/CPHA/data_in changes after cycle 0 do not affect the transfer in progress.
REQ-019 LEAD: from cycle 1 CS=0, busy=1; CPHA=0 drives MOSI=bit7 at cycle 1; CPHA=1 drives MOSI=0 at cycle 1; lasts HALF cycles.
REQ-020 XFER: exactly 16 SCLK toggles, edge k (k=1..16) at cycle 1+k*HALF; SCLK idles at latched CPOL.
REQ-021 CPHA=0: MISO sampled on odd edges, MOSI advances to next bit on even edges 2..14.
REQ-022 CPHA=1: MOSI drives next bit (bit7 first) on odd edges, MISO sampled on even edges.
REQ-023 Sampled bits shift into an 8-bit receive register from the LSB end; after 8 samples bit7 holds the first sampled bit.
REQ-024 TRAIL: CS stays 0 for HALF cycles after edge 16; at cycle 1+17*HALF (426 at defaults) CS=1, SCLK=CPOL, data_out loads receive register, done=1 for exactly one cycle.
REQ-025 GAP: CS=1, busy=1 for HALF cycles (minimum CS-high time), then IDLE with busy=0 (cycle 451 at defaults); start may be accepted that same cycle.
REQ-026 data_out holds its value until the next done; done never asserts outside TRAIL-to-GAP transition.

Reset
REQ-027 reset=1 on any clk edge, including mid-transfer: state IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, data_out=8'h00, counters and shift registers cleared; aborted transfer produces no done.

Structure
REQ-028 Package spi_pkg holds state encoding constants and the SPI mode constants (MODE0..MODE3 as {CPOL,CPHA}), shared with spi_slave.
REQ-029 Sub-module spi_clk_gen (half-period divider, enable input, one-cycle tick output every HALF cycles) is instantiated once; edge counter and shift logic stay in spi_master.

Verification
REQ-030 Mode 0, MISO looped to MOSI, data_in=8'hA5 -> data_out=8'hA5, done at cycle 426, CS low cycles 1..425, 16 SCLK edges.
REQ-031 spi_master connected to spi_slave, all four {CPOL,CPHA} modes, master 8'h3C / slave 8'hC3 -> master data_out=8'hC3, slave data_out=8'h3C each mode.
REQ-032 Second start pulse at cycle 100 of a transfer -> ignored, exactly one done, next transfer only after busy=0.
REQ-033 reset asserted at cycle 200 of a transfer -> next cycle CS=1, SCLK=0, busy=0, data_out=8'h00, no done.
REQ-034 CPOL=1 in IDLE, then CPOL toggled during XFER -> SCLK idles high before and after, toggled CPOL has no effect until next start.
REQ-035 Back-to-back starts asserted the cycle busy falls -> CS high for at least HALF cycles between transfers, both bytes correct.
